mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output. It is the next generation of the team's combinational 4:1 mux.
- Adds a registered output stage.
- Adds per-channel flow control.
- Adds a run-time mode: fixed select, or round-robin arbitration across channels.

It sits between N producer streams and a single consumer stream.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel in bits.
- SELW, $clog2(N), select/channel-index width; derived, never overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset, while rst is sampled high:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready is all-zero in any cycle where rst=1.
  - Reset mid-transfer discards the held word, with no handshake credited.
- Load enable: load_en = !out_valid || out_ready. The one-deep output register gives full throughput, one word per cycle.
- Grant (combinational, each cycle):
  - Fixed mode: grant channel = sel; grant_valid = in_valid[sel] && (sel < N).
  - Fixed mode, sel >= N: grant_valid=0 and in_ready is all-zero.
  - Round-robin mode: scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1; grant the first with in_valid=1. grant_valid=0 if none are valid.
- Input handshake:
  - in_ready[i] = load_en && grant_valid && (i == grant).
  - At most one in_ready bit is high per cycle.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On an input transfer at the clock edge:
  - out_data <= channel data; out_ch <= grant; out_valid <= 1.
  - Latency: exactly 1 cycle from the input handshake to out_valid=1.
- Output drain: if out_valid && out_ready and no input transfer occurs, out_valid <= 0; out_data and out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_ch and out_valid hold stable.
  - in_ready is all-zero.
- Pointer update:
  - Updated only on an input transfer in round-robin mode: ptr <= (grant+1) mod N. Wrap from N-1 goes to 0.
  - Never updated in fixed mode.
  - Held in cycles with no transfer.
- Mode or sel changes take effect in the same cycle and never alter a word already held in the output register.
- Producers must keep in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
Macro: MUX_NTO1_RR_STATS_EN.
- Defined:
  - Adds output port txn_cnt, 16 bits: count of output handshakes (out_valid && out_ready).
  - Reset to 0 by rst.
  - Increments by 1 per handshake and saturates at 16'hFFFF, never wrapping.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Fixed mode, N=4, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
2. Backpressure: fixed sel=0, ch0 streaming 8'h01, 8'h02, 8'h03; out_ready=0 for 3 cycles after the first load → out_data stays 8'h01 and in_ready=0 while stalled; on release, 8'h02 then 8'h03 follow back-to-back with no loss or duplication.
3. Round-robin fairness: mode=1, all four in_valid=1, out_ready=1 for 8 cycles → out_ch sequence is 0,1,2,3,0,1,2,3.
4. Round-robin skip and wrap: mode=1, only ch1 and ch3 valid, ptr=0 → grants alternate 1,3,1,3; with only ch0 valid after a grant on ch3, the next grant is ch0.
5. Illegal select: N=3, mode=0, sel=3, all in_valid=1 → in_ready=3'b000 and out_valid stays 0.
6. Reset mid-operation: assert rst for 1 cycle while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_ch=0, ptr=0.
   - With MUX_NTO1_RR_STATS_EN defined: txn_cnt=0 after reset; after 65540 handshakes it reads 16'hFFFF.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - N-to-1 stream mux with registered output, fixed-select or round-robin grant
//
// Purpose: selects one of N valid/ready producer streams and forwards the
// granted word through a one-deep output register to a single consumer.
// mode=0 grants the channel named by sel; mode=1 grants round-robin,
// starting the scan at the channel after the last one granted.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode (values >= N grant nothing)
//   in_data    N packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered output word
//   out_ch     channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
//   txn_cnt    saturating output-handshake count (MUX_NTO1_RR_STATS_EN only)
//
// Build option: define MUX_NTO1_RR_STATS_EN to add the txn_cnt port.

module mux_nto1_rr #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_NTO1_RR_STATS_EN
  ,
  output logic [15:0]          txn_cnt
`endif
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int IDXW = SELW + 1;
  localparam int NPAD = 1 << SELW;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [NPAD-1:0]  valid_pad;
  logic [IDXW-1:0]  scan_idx;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;

  // Grant selection. valid_pad widens in_valid to every encodable index so
  // an out-of-range sel or scan index simply reads as "not valid".
  always_comb begin
    valid_pad = '0;
    valid_pad[N-1:0] = in_valid;
    grant = '0;
    grant_valid = 1'b0;
    scan_idx = '0;
    if (!mode) begin
      grant = sel;
      grant_valid = valid_pad[sel] && (int'(sel) < N);
    end else begin
      // Scan from the highest offset down so the last hit written is the
      // first valid channel in ptr, ptr+1, ... order.
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = {1'b0, ptr_q} + IDXW'(k);
        if (scan_idx >= IDXW'(N)) begin
          scan_idx = scan_idx - IDXW'(N);
        end
        if (valid_pad[scan_idx[SELW-1:0]]) begin
          grant = scan_idx[SELW-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = !rst && load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant == SELW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef MUX_NTO1_RR_STATS_EN
  logic [15:0] txn_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt_q <= '0;
    end else if (out_valid_q && out_ready && (txn_cnt_q != 16'hFFFF)) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign txn_cnt = txn_cnt_q;
`else
  // Handshake counter not built.
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb/tb_mux_nto1_rr.sv - directed self-checking bench for mux_nto1_rr
module tb_mux_nto1_rr;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef MUX_NTO1_RR_STATS_EN
  logic [15:0] txn_cnt;
  logic [15:0] txn_cnt3;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_nto1_rr #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_NTO1_RR_STATS_EN
    , .txn_cnt(txn_cnt)
`endif
  );

  mux_nto1_rr #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
`ifdef MUX_NTO1_RR_STATS_EN
    , .txn_cnt(txn_cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] data);
    exp_t e;
    e.ch = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  // Output monitor: a handshake completes on the next rising edge whenever
  // out_valid && out_ready is seen mid-cycle outside reset.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_ch", 32'(out_ch), 32'(e.ch));
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_data = 32'h0; in_valid = 4'b1111; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd3; in_data3 = 24'h0; in_valid3 = 3'b000; out_ready3 = 1'b1;

    // Reset state; in_ready must stay low even with requests pending.
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    tick();
    rst = 1'b0; in_valid = 4'b0000;

    // Fixed select on channel 2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'hA5);
    tick();
    in_valid = 4'b0000;
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_data", 32'(out_data), 32'hA5);
    chk("t1_out_ch", 32'(out_ch), 32'h2);
    tick();
    chk("t1_drain", 32'(out_valid), 32'h0);

    // Backpressure on channel 0.
    sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0001;
    push(2'd0, 8'h01);
    tick();
    out_ready = 1'b0; in_data = 32'h0000_0002;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_stall_ready", 32'(in_ready), 32'h0);
      chk("t2_stall_data", 32'(out_data), 32'h01);
      chk("t2_stall_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t2_release_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h02);
    tick();
    chk("t2_word2", 32'(out_data), 32'h02);
    in_data = 32'h0000_0003;
    push(2'd0, 8'h03);
    tick();
    chk("t2_word3", 32'(out_data), 32'h03);
    in_valid = 4'b0000;
    tick();
    chk("t2_drain", 32'(out_valid), 32'h0);

    // Round-robin fairness with every channel requesting.
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_grant", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      push(2'(k % 4), 8'(8'h10 + (k % 4)));
      tick();
    end
    in_valid = 4'b0000;
    tick();

    // Round-robin skip over idle channels and wrap back to 0.
    in_valid = 4'b1010; in_data = 32'h2322_2120;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] c;
      c = (k % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      chk("t4_grant", 32'(in_ready), 32'(4'b0001 << c));
      push(c, 8'(8'h20 + c));
      tick();
    end
    in_valid = 4'b0001;
    #1;
    chk("t4_wrap", 32'(in_ready), 32'h1);
    push(2'd0, 8'h20);
    tick();
    in_valid = 4'b0000;
    tick();

    // Illegal select on a 3-channel instance.
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h33_22_11;
    #1;
    chk("t5_in_ready", 32'(in_ready3), 32'h0);
    tick();
    chk("t5_out_valid", 32'(out_valid3), 32'h0);
    tick();
    chk("t5_out_valid2", 32'(out_valid3), 32'h0);
    sel3 = 2'd2;
    #1;
    chk("t5_legal_ready", 32'(in_ready3), 32'h4);
    tick();
    chk("t5_legal_data", 32'(out_data3), 32'h33);
    chk("t5_legal_ch", 32'(out_ch3), 32'h2);
    in_valid3 = 3'b000;

    // Reset while a word is held under backpressure: it is discarded.
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h4342_4140; out_ready = 1'b0;
    tick();
    chk("t6_held", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    sb.delete();
    chk("t6_out_valid", 32'(out_valid), 32'h0);
    chk("t6_out_data", 32'(out_data), 32'h0);
    chk("t6_out_ch", 32'(out_ch), 32'h0);
`ifdef MUX_NTO1_RR_STATS_EN
    chk("t6_txn_cnt", 32'(txn_cnt), 32'h0);
`endif
    // Pointer must be back at 0: with all channels valid, ch0 wins.
    in_valid = 4'b1111;
    #1;
    chk("t6_ptr_zero", 32'(in_ready), 32'h1);
    push(2'd0, 8'h40);
    tick();
    in_valid = 4'b0000;
    tick();

`ifdef MUX_NTO1_RR_STATS_EN
    // Saturation: 1 handshake above plus 65539 more exceeds 16'hFFFF.
    mode = 1'b0; sel = 2'd0; in_data = 32'h0000_005A; in_valid = 4'b0001;
    for (int k = 0; k < 65539; k++) begin
      push(2'd0, 8'h5A);
      tick();
    end
    in_valid = 4'b0000;
    tick();
    chk("stats_sat", 32'(txn_cnt), 32'hFFFF);
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
